// File: rtl/rr_arb8_if.sv
// Request/grant bundle between the eight requesters and the round-robin scheduler.
// The master side drives requests, release strobe and data; the slave side returns the grant.
interface rr_arb8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] din;
  logic [7:0] gnt;
  logic [2:0] sel;
  logic       vld;
  logic       f;
  logic       tmo;

  modport master (output req, done, din, input gnt, sel, vld, f, tmo);
  modport slave  (input req, done, din, output gnt, sel, vld, f, tmo);
endinterface

// File: rtl/rr_arb8.sv
// 8:1 round-robin scheduler with select, grant and data mux; one-cycle grant latency, one idle cycle per release.
// Optional hold timeout compiled in with RR_ARB8_TIMEOUT_EN (bounds a grant to MAX_HOLD cycles).
module rr_arb8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  rr_arb8_if.slave   bus_if
);

  typedef enum logic {IDLE, BUSY} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb8: MAX_HOLD must be in 1..255");
  end

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [2:0] sel_q;
  logic [7:0] gnt_q;
  logic       vld_q;

  logic       pick_vld_d;
  logic [2:0] pick_idx_d;
  logic [2:0] scan_idx;
  logic       rel_ext;
  logic       tmo_hit;

  // First set request scanning upward from the pointer, wrapping 7->0.
  always_comb begin
    pick_vld_d = 1'b0;
    pick_idx_d = 3'd0;
    scan_idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_idx = ptr_q + 3'(k);
      if (!pick_vld_d && bus_if.req[scan_idx]) begin
        pick_vld_d = 1'b1;
        pick_idx_d = scan_idx;
      end
    end
  end

  assign rel_ext = bus_if.done | ~bus_if.req[sel_q];

`ifdef RR_ARB8_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_q;
  logic       tmo_q;

  assign tmo_hit = (cnt_q == HOLD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 8'd0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      if (state_q == IDLE) begin
        cnt_q <= 8'd0;
      end else if (rel_ext || tmo_hit) begin
        tmo_q <= ~rel_ext;
      end else if (cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign bus_if.tmo = tmo_q;
`else
  assign tmo_hit    = 1'b0;
  assign bus_if.tmo = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      gnt_q   <= 8'd0;
      vld_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_vld_d) begin
            sel_q   <= pick_idx_d;
            gnt_q   <= 8'd1 << pick_idx_d;
            vld_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // S keeps its last value after release; only GNT/VLD drop.
          if (rel_ext || tmo_hit) begin
            gnt_q   <= 8'd0;
            vld_q   <= 1'b0;
            ptr_q   <= sel_q + 3'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_if.gnt = gnt_q;
  assign bus_if.sel = sel_q;
  assign bus_if.vld = vld_q;
  assign bus_if.f   = vld_q & bus_if.din[sel_q];

endmodule

// File: tb/tb_rr_arb8.sv
// Self-checking bench for rr_arb8: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural round-robin model.
module tb_rr_arb8;
  localparam int MH = 4;
`ifdef RR_ARB8_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   chk_en = 1'b0;

  rr_arb8_if bus_if ();

  rr_arb8 #(.MAX_HOLD(MH)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  // Behavioural model: busy flag, granted index, pointer, cycles held so far.
  bit m_busy;
  int m_sel, m_ptr, m_held;
  bit m_to;

  always @(posedge clk) begin
    bit found;
    m_to = 1'b0;
    if (rst) begin
      m_busy = 0; m_sel = 0; m_ptr = 0; m_held = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        if (!found && bus_if.req[(m_ptr + k) % 8]) begin
          found = 1; m_sel = (m_ptr + k) % 8;
        end
      end
      if (found) begin m_busy = 1; m_held = 1; end
    end else begin
      if (bus_if.done || !bus_if.req[m_sel] || (TMO_ON && m_held == MH)) begin
        m_to   = TMO_ON && !bus_if.done && bus_if.req[m_sel];
        m_busy = 0;
        m_ptr  = (m_sel + 1) % 8;
      end else begin
        m_held++;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    int exp_gnt, exp_f;
    if (chk_en) begin
      exp_gnt = m_busy ? (1 << m_sel) : 0;
      exp_f   = m_busy ? int'(bus_if.din[m_sel]) : 0;
      check("model_gnt", int'(bus_if.gnt), exp_gnt);
      check("model_sel", int'(bus_if.sel), m_sel);
      check("model_vld", int'(bus_if.vld), int'(m_busy));
      check("model_f",   int'(bus_if.f),   exp_f);
      check("model_to",  int'(bus_if.tmo), int'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; bus_if.req = '0; bus_if.done = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int hi, to_cnt;
    bus_if.req = '0; bus_if.done = 1'b0; bus_if.din = '0;
    tick(); tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_gnt", int'(bus_if.gnt), 0);
    check("rst_vld", int'(bus_if.vld), 0);
    check("rst_sel", int'(bus_if.sel), 0);

    // Single request, data path, release and pointer advance with wrap scan.
    bus_if.req = 8'h10; tick();
    check("single_gnt", int'(bus_if.gnt), 8'h10);
    check("single_sel", int'(bus_if.sel), 4);
    check("single_vld", int'(bus_if.vld), 1);
    bus_if.din = 8'h10; #1;
    check("single_f", int'(bus_if.f), 1);
    bus_if.done = 1'b1; tick(); bus_if.done = 1'b0;
    check("single_rel", int'(bus_if.gnt), 0);
    check("single_rel_f", int'(bus_if.f), 0);
    bus_if.req = 8'h21; tick();
    check("ptr5_sel", int'(bus_if.sel), 5);
    bus_if.done = 1'b1; tick(); bus_if.done = 1'b0;
    bus_if.req = 8'h03; tick();
    check("wrap_sel0", int'(bus_if.sel), 0);
    bus_if.done = 1'b1; tick(); bus_if.done = 1'b0;
    check("wrap_gap", int'(bus_if.vld), 0);
    tick();
    check("wrap_sel1", int'(bus_if.sel), 1);

    // Rotation with one idle cycle between grants.
    do_reset();
    bus_if.req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("rot_sel", int'(bus_if.sel), i % 8);
      check("rot_vld", int'(bus_if.vld), 1);
      bus_if.done = 1'b1; tick(); bus_if.done = 1'b0;
      check("rot_gap", int'(bus_if.vld), 0);
    end

    // Withdrawal, then DONE while idle must not move the pointer.
    do_reset();
    bus_if.req = 8'h04; tick();
    check("wd_sel", int'(bus_if.sel), 2);
    bus_if.req = 8'h00; tick();
    check("wd_rel", int'(bus_if.vld), 0);
    bus_if.done = 1'b1; tick(); bus_if.done = 1'b0;
    check("idle_done", int'(bus_if.vld), 0);
    bus_if.req = 8'hFF; tick();
    check("wd_ptr3", int'(bus_if.sel), 3);

    // Hold timeout (or indefinite hold without it).
    do_reset();
    bus_if.req = 8'h01; tick();
    hi = 0; to_cnt = 0;
    if (TMO_ON) begin
      for (int k = 0; k < 5; k++) begin
        hi += int'(bus_if.vld); to_cnt += int'(bus_if.tmo);
        if (k < 4) tick();
      end
      check("tmo_hold", hi, MH);
      check("tmo_pulse", to_cnt, 1);
      tick();
      check("tmo_regrant_vld", int'(bus_if.vld), 1);
      check("tmo_regrant_sel", int'(bus_if.sel), 0);
      check("tmo_clear", int'(bus_if.tmo), 0);
    end else begin
      for (int k = 0; k < 20; k++) begin
        hi += int'(bus_if.vld); to_cnt += int'(bus_if.tmo);
        tick();
      end
      check("hold_forever", hi, 20);
      check("no_tmo", to_cnt, 0);
    end

    // Reset in the middle of a grant.
    do_reset();
    bus_if.req = 8'h20; tick();
    check("mid_sel", int'(bus_if.sel), 5);
    bus_if.din = 8'hFF; rst = 1'b1; tick();
    check("mid_gnt", int'(bus_if.gnt), 0);
    check("mid_s",   int'(bus_if.sel), 0);
    check("mid_vld", int'(bus_if.vld), 0);
    check("mid_f",   int'(bus_if.f),   0);
    rst = 1'b0; tick();
    check("mid_regrant", int'(bus_if.sel), 5);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus_if.req = 8'($urandom);
      else if ($urandom_range(0, 5) == 0) bus_if.req = bus_if.req ^ (8'd1 << $urandom_range(0, 7));
      bus_if.done = ($urandom_range(0, 4) == 0);
      bus_if.din  = 8'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; bus_if.done = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb8.md
# rr_arb8

Round-robin scheduler for the 8:1 single-bit selector datapath. Eight requesters contend for the one shared output path. The block grants exactly one requester at a time and drives the 3-bit select for that requester. While a grant is active, the selected data bit is presented on F. An optional hold timeout bounds how long any one requester can keep the path.

## Interface
- MAX_HOLD, 16, maximum grant length in cycles when the timeout is compiled in; legal range 1..255.
- CLK  input  1  clock; all state changes on the rising edge.
- RST  input  1  synchronous, active-high reset.
- REQ  input  8  request lines, one per requester; level-sensitive, bit k = requester k.
- DONE  input  1  release strobe from the granted requester; sampled only in BUSY.
- I  input  8  data bits, one per requester.
- GNT  output  8  one-hot grant, registered; all zero when no grant is active.
- S  output  3  registered select (index of the granted requester).
- VLD  output  1  registered; high while a grant is active.
- F  output  1  combinational; equals I[S] when VLD=1, otherwise 0.
- TO  output  1  registered one-cycle pulse marking a timeout release; tied 0 when the timeout is not compiled in.

## Operation
- Internal state:
  - PTR[2:0], the priority pointer.
  - CNT[7:0], the hold counter.
  - FSM with two states, IDLE and BUSY.
- IDLE:
  - If REQ ≠ 0, choose the first set bit scanning upward from PTR, wrapping 7→0.
  - Load S with that index and set GNT to one-hot(S). Set VLD=1 and CNT=0, then go to BUSY.
  - If REQ = 0, stay in IDLE with all outputs zero.
- BUSY release conditions (any one of these releases the grant):
  - DONE=1.
  - REQ[S]=0, meaning the requester withdrew.
  - Timeout: CNT == MAX_HOLD-1, only when the timeout is compiled in.
- BUSY on release:
  - GNT=0 and VLD=0.
  - PTR = S+1, modulo 8 (7 wraps to 0).
  - Go to IDLE.
  - S holds its last value. F reads 0 because VLD=0.
- BUSY otherwise: increment CNT (saturating at 255) and hold GNT, S and VLD.
- Simultaneous release conditions produce a single release. TO=1 only when the timeout is the release cause and neither DONE nor the REQ drop is present.
- DONE seen in IDLE is ignored.
- Changes to REQ bits other than REQ[S] during BUSY have no effect.
- GNT is always one-hot or zero, and GNT == one-hot(S) whenever VLD=1.
- Reset:
  - When RST=1 at an edge, all of the following clear: GNT, S, VLD and TO to 0; PTR to 0; CNT to 0; FSM to IDLE.
  - Reset overrides every other input, including a grant that is in progress.

## Timing
- Grant latency: REQ sampled at edge N in IDLE gives GNT, S and VLD valid after edge N.
- Release: a release condition sampled at edge M gives GNT=0 and VLD=0 after edge M. TO is high for the single cycle after edge M.
- IDLE lasts at least one cycle after every release, so back-to-back grants have a one-cycle gap. The earliest new grant appears after edge M+1.
- With the timeout, a grant that is never released by DONE or a REQ drop stays active for exactly MAX_HOLD cycles.
- F has zero-cycle latency from I and S; it is a combinational path only.

## Configuration
- RR_ARB8_TIMEOUT_EN defined:
  - The CNT compare against MAX_HOLD-1 forces release and pulses TO.
- RR_ARB8_TIMEOUT_EN not defined:
  - The grant is held until DONE or a REQ[S] drop.
  - TO is constant 0.
  - CNT and the compare logic are removed; MAX_HOLD is unused.

## Test plan
- Reset then single request: release RST, then REQ=8'h10 → one cycle later GNT=8'h10, S=4, VLD=1. Setting I[4]=1 gives F=1. After DONE pulse, GNT=0 and PTR=5.
- Rotation: REQ=8'hFF held, DONE pulsed every grant → S sequence 0,1,2,…,7,0, with one idle cycle between grants.
- Wrap scan: PTR=6 (after a grant to 5), REQ=8'h03 → S=0, then after release S=1.
- Withdrawal and ignored DONE:
  - Granted requester 2 drops REQ[2] with no DONE → release on that edge and PTR=3.
  - DONE pulsed in IDLE → no state change.
- Timeout (macro defined, MAX_HOLD=4): REQ=8'h01 held, no DONE → VLD high for exactly 4 cycles, TO=1 for one cycle, then a regrant to 0 after the idle cycle. Without the macro, VLD stays high indefinitely and TO=0.
- Reset mid-grant: RST=1 during BUSY with S=5 → next cycle GNT=0, S=0, VLD=0 and F=0. After RST=0, REQ=8'h20 → grant to 5 (PTR back at 0).
